// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register word offsets, CTRL/INTSTAT bit
// positions and the APB transfer-state encoding.
package apb_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_LOAD     = 3'd1;
    localparam logic [2:0] REG_VALUE    = 3'd2;
    localparam logic [2:0] REG_PRESCALE = 3'd3;
    localparam logic [2:0] REG_INTSTAT  = 3'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQEN   = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int INTSTAT_BIT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_t;

    function automatic logic reg_mapped(input logic [2:0] idx);
        return idx <= REG_INTSTAT;
    endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: emits a one-cycle tick every PRESCALE+1 enabled
// cycles; held at zero while disabled and restartable from the register file.
module apb_timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] prescale,
    input  logic       en,
    input  logic       restart,
    output logic       tick
);

    logic [7:0] pre_cnt;

    assign tick = en && (pre_cnt == prescale);

    // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || restart || !en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB completer with a 32-bit down-counting timer, prescaler and sticky interrupt.
// Define APB3_EN to add PREADY/PSLVERR with WAIT_CYCLES access wait states.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic [ADDRWIDTH-1:0] PADDR,
    input  logic                 PWRITE,
    input  logic [DATAWIDTH-1:0] PWDATA,
    output logic [DATAWIDTH-1:0] PRDATA,
    output logic                 TIMERINT
`ifdef APB3_EN
    ,
    output logic                 PREADY,
    output logic                 PSLVERR
`endif
);

    localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

    apb_state_t           state, next_state;
    logic [2:0]           idx;
    logic                 setup_ph, access_ph, in_xfer, commit, write_en, err;
    logic                 ready, wait_done, tick, load_wr, unused_bits;
    logic [2:0]           ctrl;
    logic [DATAWIDTH-1:0] load, value, rdata;
    logic [7:0]           prescale;
    logic                 intstat;

    assign idx       = PADDR[4:2];
    assign setup_ph  = PSEL && !PENABLE;
    assign access_ph = PSEL && PENABLE;
    assign in_xfer   = access_ph && (state != ST_IDLE);
    assign commit    = in_xfer && wait_done;
    assign write_en  = commit && PWRITE && !err;
    assign load_wr   = write_en && (idx == REG_LOAD);

`ifdef APB3_EN
    logic [3:0] wait_cnt;

    assign wait_done = (wait_cnt == WAIT_CYCLES[3:0]);
    assign err       = !reg_mapped(idx) || (PWRITE && (idx == REG_VALUE));
    assign PREADY    = ready || PRESET;
    assign PSLVERR   = commit && err && !PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET || setup_ph) begin
            wait_cnt <= '0;
        end else if (in_xfer && !wait_done) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign unused_bits = ^{PADDR[ADDRWIDTH-1:5], PADDR[1:0]};
`else
    assign wait_done   = 1'b1;
    assign err         = 1'b0;
    assign unused_bits = ^{PADDR[ADDRWIDTH-1:5], PADDR[1:0], ready, WAIT_CYCLES[3:0]};
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= ST_IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        ready      = 1'b1;
        if (!PSEL) begin
            next_state = ST_IDLE;
        end else if (!PENABLE) begin
            next_state = ST_SETUP;
        end else if (state != ST_IDLE) begin
            ready      = wait_done;
            next_state = wait_done ? ST_IDLE : ST_ACCESS;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            REG_CTRL:     rdata[2:0]        = ctrl;
            REG_LOAD:     rdata             = load;
            REG_VALUE:    rdata             = value;
            REG_PRESCALE: rdata[7:0]        = prescale;
            REG_INTSTAT:  rdata[INTSTAT_BIT] = intstat;
            default:      rdata             = '0;
        endcase
    end

    apb_timer_prescaler u_prescaler (
        .clk      (PCLK),
        .rst      (PRESET),
        .prescale (prescale),
        .en       (ctrl[CTRL_EN]),
        .restart  (write_en && (idx == REG_LOAD || idx == REG_PRESCALE)),
        .tick     (tick)
    );

    // Later assignments win: a counter event overrides a coincident INTSTAT clear
    // and a coincident CTRL write of EN.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl     <= '0;
            load     <= '0;
            value    <= '0;
            prescale <= '0;
            intstat  <= 1'b0;
            PRDATA   <= '0;
        end else begin
            if (write_en) begin
                case (idx)
                    REG_CTRL:     ctrl     <= PWDATA[2:0];
                    REG_LOAD:     load     <= PWDATA;
                    REG_PRESCALE: prescale <= PWDATA[7:0];
                    REG_INTSTAT:  if (PWDATA[INTSTAT_BIT]) intstat <= 1'b0;
                    default:      ;
                endcase
            end
            if (load_wr) begin
                value <= PWDATA;
            end else if (tick) begin
                if (value > ONE) begin
                    value <= value - ONE;
                end else begin
                    intstat <= 1'b1;
                    if (ctrl[CTRL_ONESHOT]) begin
                        value         <= '0;
                        ctrl[CTRL_EN] <= 1'b0;
                    end else begin
                        value <= load;
                    end
                end
            end
            if (setup_ph) PRDATA <= rdata;
        end
    end

    assign TIMERINT = intstat && ctrl[CTRL_IRQEN];

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: directed scenarios plus randomized APB traffic
// compared against a behavioural model of the register map and timer rules.
module tb_apb_timer;

`ifdef APB3_EN
    localparam int WAITV = 2;
    localparam bit APB3  = 1'b1;
`else
    localparam int WAITV = 0;
    localparam bit APB3  = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        TIMERINT;
`ifdef APB3_EN
    logic        PREADY, PSLVERR;
`endif

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_timer #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAIT_CYCLES(WAITV)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .TIMERINT (TIMERINT)
`ifdef APB3_EN
        ,
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [2:0]  m_ctrl;
    logic [31:0] m_load, m_value, m_rdata;
    logic [7:0]  m_ps;
    int          m_pre, m_wait;
    logic        m_int, m_xfer;

    function automatic logic [31:0] model_read(input logic [2:0] i);
        case (i)
            3'd0:    return {29'b0, m_ctrl};
            3'd1:    return m_load;
            3'd2:    return m_value;
            3'd3:    return {24'b0, m_ps};
            3'd4:    return {31'b0, m_int};
            default: return 32'b0;
        endcase
    endfunction

    function automatic logic model_err(input logic [15:0] addr, input logic wr);
        return APB3 && ((addr[4:2] > 3'd4) || (wr && addr[4:2] == 3'd2));
    endfunction

    always @(posedge PCLK) begin : model
        logic [2:0]  idx, n_ctrl;
        logic [31:0] n_load, n_val;
        logic [7:0]  n_ps;
        logic        commit, wr, tick, n_int;
        int          n_pre;
        if (PRESET) begin
            m_ctrl <= '0; m_load <= '0; m_value <= '0; m_ps <= '0; m_pre <= 0;
            m_int <= 1'b0; m_rdata <= '0; m_xfer <= 1'b0; m_wait <= 0;
        end else begin
            idx    = PADDR[4:2];
            commit = PSEL && PENABLE && m_xfer && (m_wait == WAITV);
            wr     = commit && PWRITE && !model_err(PADDR, PWRITE);
            tick   = m_ctrl[0] && (m_pre == int'(m_ps));
            n_ctrl = m_ctrl; n_load = m_load; n_val = m_value; n_ps = m_ps; n_int = m_int;
            if (wr) begin
                case (idx)
                    3'd0: n_ctrl = PWDATA[2:0];
                    3'd1: n_load = PWDATA;
                    3'd3: n_ps   = PWDATA[7:0];
                    3'd4: if (PWDATA[0]) n_int = 1'b0;
                    default: ;
                endcase
            end
            // A LOAD write replaces the value and swallows any tick of that cycle.
            if (wr && idx == 3'd1) begin
                n_val = PWDATA;
            end else if (tick) begin
                if (m_value > 32'd1) begin
                    n_val = m_value - 32'd1;
                end else begin
                    n_int = 1'b1;
                    if (m_ctrl[2]) begin
                        n_val     = 32'd0;
                        n_ctrl[0] = 1'b0;
                    end else begin
                        n_val = m_load;
                    end
                end
            end
            if (!m_ctrl[0] || tick || (wr && (idx == 3'd1 || idx == 3'd3))) n_pre = 0;
            else n_pre = m_pre + 1;
            if (PSEL && !PENABLE) m_rdata <= model_read(idx);
            if (PSEL && !PENABLE) begin
                m_xfer <= 1'b1; m_wait <= 0;
            end else if (PSEL && PENABLE && m_xfer) begin
                if (m_wait == WAITV) m_xfer <= 1'b0;
                else m_wait <= m_wait + 1;
            end else if (!PSEL) begin
                m_xfer <= 1'b0;
            end
            m_ctrl <= n_ctrl; m_load <= n_load; m_value <= n_val; m_ps <= n_ps;
            m_pre <= n_pre; m_int <= n_int;
        end
    end

    // ---------------- bus driver ----------------
    task automatic apb_xfer(input string tag, input logic wr, input logic [15:0] addr,
                            input logic [31:0] data, output logic [31:0] rd);
        int n;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
`ifdef APB3_EN
        n = 0;
        while (!PREADY && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        check({tag, "_waits"}, 32'(n), 32'(WAITV));
        check({tag, "_slverr"}, {31'b0, PSLVERR}, {31'b0, model_err(addr, wr)});
`else
        n = 0;
`endif
        rd = PRDATA;
        if (!wr) begin
            check({tag, "_rdata"}, rd, m_rdata);
            check({tag, "_irq"}, {31'b0, TIMERINT}, {31'b0, m_int & m_ctrl[1]});
        end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        apb_xfer("wr", 1'b1, addr, data, dummy);
    endtask

    task automatic rd_reg(input string tag, input logic [15:0] addr, output logic [31:0] rd);
        apb_xfer(tag, 1'b0, addr, 32'h0, rd);
    endtask

    initial begin
        logic [31:0] rd;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        // Reset state.
        for (int i = 0; i < 5; i++) begin
            rd_reg("reset_rd", 16'(i * 4), rd);
            check("reset_val", rd, 32'h0);
        end
        check("reset_irq", {31'b0, TIMERINT}, 32'h0);

`ifndef APB3_EN
        // Periodic, LOAD=3, PRESCALE=0: events three cycles apart.
        wr_reg(16'h04, 32'd3);
        wr_reg(16'h0C, 32'd0);
        wr_reg(16'h00, 32'h3);
        @(negedge PCLK); check("per_irq_c1", {31'b0, TIMERINT}, 32'h0);
        @(negedge PCLK); check("per_irq_c2", {31'b0, TIMERINT}, 32'h0);
        @(negedge PCLK); check("per_irq_c3", {31'b0, TIMERINT}, 32'h1);
        wr_reg(16'h10, 32'h1);
        check("w1c_later", {31'b0, TIMERINT}, 32'h0);
        @(negedge PCLK); check("per_irq_c6", {31'b0, TIMERINT}, 32'h1);
        @(negedge PCLK);
        wr_reg(16'h10, 32'h1);
        check("w1c_vs_event", {31'b0, TIMERINT}, 32'h1);
        rd_reg("per_val", 16'h08, rd); check("per_val_3", rd, 32'd3);
        rd_reg("per_val", 16'h08, rd); check("per_val_1", rd, 32'd1);

        // One-shot, LOAD=2, PRESCALE=4: single event 10 cycles after enabling.
        wr_reg(16'h00, 32'h0);
        wr_reg(16'h10, 32'h1);
        wr_reg(16'h04, 32'd2);
        wr_reg(16'h0C, 32'd4);
        wr_reg(16'h00, 32'h7);
        repeat (9) @(negedge PCLK);
        check("os_irq_c9", {31'b0, TIMERINT}, 32'h0);
        @(negedge PCLK);
        check("os_irq_c10", {31'b0, TIMERINT}, 32'h1);
        rd_reg("os_ctrl", 16'h00, rd); check("os_en_clear", rd, 32'h6);
        repeat (20) @(negedge PCLK);
        rd_reg("os_val", 16'h08, rd); check("os_val_0", rd, 32'h0);

        // LOAD write lands on a tick that would otherwise be an event.
        wr_reg(16'h00, 32'h0);
        wr_reg(16'h10, 32'h1);
        wr_reg(16'h04, 32'd2);
        wr_reg(16'h0C, 32'd0);
        wr_reg(16'h00, 32'h1);
        wr_reg(16'h04, 32'd5);
        rd_reg("ldtick_val", 16'h08, rd); check("ldtick_val_5", rd, 32'd5);
        rd_reg("ldtick_int", 16'h10, rd); check("ldtick_no_event", rd, 32'h0);
`else
        // Unmapped read with wait states: error response and zero data.
        rd_reg("unmapped", 16'h14, rd);
        check("unmapped_data", rd, 32'h0);
`endif

        // Reset in the middle of a transfer: the write is lost.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h04; PWDATA = 32'h1234;
        @(negedge PCLK);
        PENABLE = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        rd_reg("midrst", 16'h04, rd); check("midrst_load", rd, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  idx;
            logic [15:0] addr;
            logic [31:0] data;
            logic        wr;
            idx  = 3'($urandom_range(0, 7));
            addr = {11'($urandom), idx, 2'b00};
            wr   = ($urandom_range(0, 2) != 0);
            case (idx)
                3'd1:    data = 32'($urandom_range(0, 12));
                3'd3:    data = {24'($urandom), 8'($urandom_range(0, 3))};
                default: data = $urandom;
            endcase
            apb_xfer("rand", wr, addr, data, rd);
            repeat ($urandom_range(0, 3)) @(negedge PCLK);
        end
        for (int i = 0; i < 5; i++) rd_reg("final", 16'(i * 4), rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
